municao_inimiga: RTL and testbench
==================================

Name: municao_inimiga

Overview:
Enemy projectile generator for the Space Invaders datapath. It is the writer of the posX_Municao2/posY_Municao2 pair that the player-ship block reads for its hit test.
- Picks a live enemy column pseudo-randomly and launches a shot from the formation's bottom edge.
- Moves the shot down at a fixed tick rate and retires it at the screen floor.
- Renders the shot pixel-by-pixel against the VGA counters.

Parameters:
- COLS, 11, number of enemy columns (max 16).
- COL_PITCH, 40, horizontal pixel distance between columns.
- COL_OFFSET, 10, shot x offset inside a column.
- STEP_DIV, 200000, clk cycles per movement tick.
- SPEED, 3, pixels moved down per tick.
- Y_END, 520, y at or beyond which the shot retires.
- COOLDOWN, 60, ticks spent idle between shots.
- SEED, 16'hACE1, LFSR reset value (nonzero).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- reiniciar  in  1  synchronous game restart; same effect as reset.
- vivo_jogador  in  2  player alive flag; bit0 = 0 means dead.
- formacao_x  in  11  x of the formation's left edge.
- formacao_y  in  11  y of the formation's bottom edge (launch y).
- colunas_vivas  in  COLS  bit i = column i has at least one enemy.
- h_counter  in  10  VGA column.
- v_counter  in  10  VGA line.
- posX_Municao2  out  11  shot x.
- posY_Municao2  out  11  shot y.
- tiro_ativo_inimigo  out  1  high while the shot is in flight or held.
- R, G, B  out  8 each  pixel colour.

Behaviour:
Reset values (reset, or reiniciar on a clock edge):
- State IDLE, cooldown counter = COOLDOWN, tick divider = 0, LFSR = SEED.
- posX = 0, posY = 0 (parked below the player's 489 hit threshold), tiro_ativo_inimigo = 0, RGB = 0.

Free-running counters:
- tick pulses for one cycle every STEP_DIV cycles.
- LFSR is 16-bit Fibonacci, taps 16,14,13,11, advances every cycle.

State machine:
- IDLE: decrement cooldown on each tick. When cooldown is 0, colunas_vivas != 0 and vivo_jogador[0] = 1, go to SELECT next cycle. While colunas_vivas = 0, stay in IDLE with the counter at 0.
- SELECT: idx = LFSR[3:0]. If idx < COLS and colunas_vivas[idx] = 1:
  - posX = formacao_x + idx*COL_PITCH + COL_OFFSET (11-bit, wrap ignored);
  - posY = formacao_y;
  - tiro_ativo_inimigo = 1; go to FLIGHT.
  Otherwise retry next cycle. A live column is always hit within 2^16 cycles.
- FLIGHT: on tick, if posY + SPEED >= Y_END, park (posX = posY = 0), tiro_ativo_inimigo = 0, reload cooldown, go to IDLE. Otherwise posY += SPEED. The sum is computed in 12 bits so it cannot wrap.
- HOLD: entered from FLIGHT when vivo_jogador[0] = 0.
  - Position is frozen and tiro_ativo_inimigo stays 1.
  - Left only by reset or reiniciar.
  - vivo_jogador low in IDLE or SELECT blocks launch; no HOLD is entered.

Simultaneous events:
- reiniciar wins over tick and over state transitions.
- A tick and vivo low in the same cycle resolve to HOLD with no move.

Rendering:
- Sprite is 2 px wide by 8 px tall, anchored at (posX, posY).
- Active pixel: h_counter in [posX, posX+2) and v_counter in [posY, posY+8), only when tiro_ativo_inimigo = 1.
- Active colour is R = FF, G = 40, B = 00; all other pixels are 0.
- RGB is registered, 1 cycle after the counters.

Decomposition:
- Shared package: screen limits (H_MIN 134, H_MAX 765, PLAYER_Y 490, Y_END), a colour-constant localparam, and the state encoding (IDLE, SELECT, FLIGHT, HOLD as 2-bit constants).
- One sub-module, lfsr16, with inputs clk, reset and seed and a 16-bit state output. It is reused later for enemy-march jitter.

Test Plan:
Bench parameters: COLS = 4, COL_PITCH = 40, COL_OFFSET = 10, STEP_DIV = 4, SPEED = 4, COOLDOWN = 3, Y_END = 100.
1. Reset held, then released with colunas_vivas = 4'b1111, formacao_x = 200, formacao_y = 60 -> posX/posY = 0/0 during reset. After 3 ticks, SELECT launches: posY = 60, posX ∈ {210, 250, 290, 330}, tiro_ativo_inimigo = 1.
2. Flight from 60 -> posY goes 64, 68, …, 96 (one step per 4 clocks). On the next tick (96+4 >= 100) it parks at 0/0, tiro_ativo_inimigo = 0, and the cooldown restarts.
3. colunas_vivas = 4'b0100 -> every launch has posX = 200 + 2*40 + 10 = 290. With colunas_vivas = 0 -> no launch over 1000 cycles.
4. vivo_jogador drops to 0 mid-flight at posY = 72 -> posY stays 72 and tiro_ativo_inimigo stays 1 indefinitely. reiniciar pulse -> IDLE with 0/0.
5. Async reset asserted mid-flight between clock edges -> outputs go to 0 immediately without a clock edge. The LFSR equals SEED after release.
6. Rendering with shot at (300, 80) -> on the cycle after h = 301, v = 87, RGB = FF/40/00. At h = 302 or v = 88, RGB = 0. A parked shot never draws.

Source files
------------

// File: rtl/municao_inimiga_pkg.sv
// municao_inimiga_pkg: screen limits, shot colour and shot FSM encoding shared by the enemy-shot blocks
package municao_inimiga_pkg;
  localparam int H_MIN = 134;
  localparam int H_MAX = 765;
  localparam int PLAYER_Y = 490;
  localparam int Y_END = 520;
  localparam logic [23:0] SHOT_RGB = 24'hFF4000;
  typedef enum logic [1:0] {IDLE = 2'd0, SELECT = 2'd1, FLIGHT = 2'd2, HOLD = 2'd3} state_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle and reloads seed on reset or load
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] state
);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= seed;
    else state <= load ? seed : {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
endmodule

// File: rtl/municao_inimiga.sv
// municao_inimiga: enemy shot launcher, mover and sprite renderer
module municao_inimiga #(
  parameter int          COLS       = 11,
  parameter int          COL_PITCH  = 40,
  parameter int          COL_OFFSET = 10,
  parameter int          STEP_DIV   = 200000,
  parameter int          SPEED      = 3,
  parameter int          Y_END      = municao_inimiga_pkg::Y_END,
  parameter int          COOLDOWN   = 60,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reiniciar,
  input  logic [1:0]      vivo_jogador,
  input  logic [10:0]     formacao_x,
  input  logic [10:0]     formacao_y,
  input  logic [COLS-1:0] colunas_vivas,
  input  logic [9:0]      h_counter,
  input  logic [9:0]      v_counter,
  output logic [10:0]     posX_Municao2,
  output logic [10:0]     posY_Municao2,
  output logic            tiro_ativo_inimigo,
  output logic [7:0]      R,
  output logic [7:0]      G,
  output logic [7:0]      B
);
  import municao_inimiga_pkg::*;
  localparam int DW = $clog2(STEP_DIV + 1);
  localparam int CW = $clog2(COOLDOWN + 1);
  state_t state, state_n;
  logic [DW-1:0] div;
  logic [CW-1:0] cd, cd_n;
  logic [10:0] px, py, px_n, py_n;
  logic act, act_n, tick, col_ok, pix;
  logic [15:0] lfsr, vivas16;
  logic [3:0] idx;
  logic [10:0] x_launch;
  logic [11:0] y_step, h12, v12;
  logic [23:0] rgb;
  logic unused_ok;
  lfsr16 u_lfsr (.clk(clk), .reset(reset), .load(reiniciar), .seed(SEED), .state(lfsr));
  assign unused_ok = ^{vivo_jogador[1], lfsr[15:4]};
  assign tick = div == DW'(STEP_DIV - 1);
  assign idx = lfsr[3:0];
  assign vivas16 = 16'(colunas_vivas);
  assign col_ok = (32'(idx) < COLS) && vivas16[idx];
  assign x_launch = formacao_x + 11'(idx) * 11'(COL_PITCH) + 11'(COL_OFFSET);
  assign y_step = {1'b0, py} + 12'(SPEED);
  always_comb begin
    state_n = state;
    cd_n = cd;
    px_n = px;
    py_n = py;
    act_n = act;
    case (state)
      IDLE: begin
        cd_n = (tick && cd != '0) ? cd - CW'(1) : cd;
        state_n = (cd == '0 && |colunas_vivas && vivo_jogador[0]) ? SELECT : IDLE;
      end
      SELECT: if (col_ok) begin
        px_n = x_launch;
        py_n = formacao_y;
        act_n = 1'b1;
        state_n = FLIGHT;
      end
      FLIGHT:
        if (!vivo_jogador[0]) state_n = HOLD;
        else if (tick && y_step >= 12'(Y_END)) begin
          px_n = '0;
          py_n = '0;
          act_n = 1'b0;
          cd_n = CW'(COOLDOWN);
          state_n = IDLE;
        end else if (tick) py_n = y_step[10:0];
      HOLD: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset || reiniciar) begin
      state <= IDLE;
      div <= '0;
      cd <= CW'(COOLDOWN);
      px <= '0;
      py <= '0;
      act <= 1'b0;
    end else begin
      state <= state_n;
      div <= tick ? '0 : div + DW'(1);
      cd <= cd_n;
      px <= px_n;
      py <= py_n;
      act <= act_n;
    end
  // widened compares so posX+2 / posY+8 never wrap near the 11-bit limit
  assign h12 = {2'b0, h_counter};
  assign v12 = {2'b0, v_counter};
  assign pix = act && h12 >= {1'b0, px} && h12 < {1'b0, px} + 12'd2 && v12 >= {1'b0, py} && v12 < {1'b0, py} + 12'd8;
  always_ff @(posedge clk or posedge reset)
    if (reset || reiniciar) rgb <= '0;
    else rgb <= pix ? SHOT_RGB : '0;
  assign posX_Municao2 = px;
  assign posY_Municao2 = py;
  assign tiro_ativo_inimigo = act;
  assign {R, G, B} = rgb;
endmodule

// File: tb/tb_municao_inimiga.sv
// tb_municao_inimiga: directed scoreboard bench for the enemy shot block
module tb_municao_inimiga;
  logic clk = 0, reset = 1, reiniciar = 0;
  logic [1:0] vivo = 2'b01;
  logic [10:0] fx = 11'd200, fy = 11'd60;
  logic [3:0] vivas = 4'b1111;
  logic [9:0] h = '0, v = '0;
  logic [10:0] px, py;
  logic tiro;
  logic [7:0] R, G, B;
  int tests = 0, fails = 0, seen = 0;
  logic [31:0] exp_q[$];
  logic [9:0] th[6] = '{10'd301, 10'd300, 10'd302, 10'd301, 10'd299, 10'd300};
  logic [9:0] tv[6] = '{10'd87, 10'd80, 10'd87, 10'd88, 10'd80, 10'd79};
  logic [23:0] trgb[6] = '{24'hFF4000, 24'hFF4000, 24'h0, 24'h0, 24'h0, 24'h0};
  municao_inimiga #(.COLS(4), .COL_PITCH(40), .COL_OFFSET(10), .STEP_DIV(4), .SPEED(4),
                    .Y_END(100), .COOLDOWN(3), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .reiniciar(reiniciar), .vivo_jogador(vivo),
    .formacao_x(fx), .formacao_y(fy), .colunas_vivas(vivas), .h_counter(h), .v_counter(v),
    .posX_Municao2(px), .posY_Municao2(py), .tiro_ativo_inimigo(tiro), .R(R), .G(G), .B(B));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_tiro(input string tag, input logic want);
    int k = 0;
    while (tiro !== want && k < 3000) begin
      step();
      k++;
    end
    check(tag, 32'(tiro), 32'(want));
  endtask
  task automatic flight(input logic [10:0] y0);
    for (logic [10:0] y = y0 + 11'd4; y < 11'd100; y += 11'd4) exp_q.push_back(32'(y));
    exp_q.push_back(32'd0);
    while (exp_q.size() > 0) begin
      logic [10:0] prev = py;
      int k = 0;
      while (py === prev && k < 20) begin
        step();
        k++;
      end
      check("flight_y", 32'(py), exp_q.pop_front());
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step(3);
    check("rst_x", 32'(px), 0);
    check("rst_y", 32'(py), 0);
    check("rst_tiro", 32'(tiro), 0);
    check("rst_rgb", {8'h0, R, G, B}, 0);
    check("rst_lfsr", 32'(dut.u_lfsr.state), 32'hACE1);
    reset = 0;
    step(10);
    check("cooldown_idle", 32'(tiro), 0);
    wait_tiro("launch1", 1'b1);
    check("launch1_y", 32'(py), 60);
    check("launch1_x_set", 32'(px == 210 || px == 250 || px == 290 || px == 330), 1);
    flight(11'd60);
    check("park_tiro", 32'(tiro), 0);
    vivas = 4'b0100;
    step(10);
    check("cooldown_restart", 32'(tiro), 0);
    for (int i = 0; i < 2; i++) begin
      wait_tiro("launch_col2", 1'b1);
      check("col2_x", 32'(px), 290);
      check("col2_y", 32'(py), 60);
      wait_tiro("park_col2", 1'b0);
    end
    vivas = 4'b0000;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tiro) seen++;
    end
    check("no_cols_no_launch", 32'(seen), 0);
    check("no_cols_y", 32'(py), 0);
    vivas = 4'b1111;
    wait_tiro("launch_hold", 1'b1);
    for (int k = 0; k < 40 && py !== 11'd72; k++) step();
    check("reach_72", 32'(py), 72);
    vivo = 2'b00;
    step(50);
    check("hold_y", 32'(py), 72);
    check("hold_tiro", 32'(tiro), 1);
    reiniciar = 1;
    step();
    reiniciar = 0;
    check("reinit_x", 32'(px), 0);
    check("reinit_y", 32'(py), 0);
    check("reinit_tiro", 32'(tiro), 0);
    check("reinit_lfsr", 32'(dut.u_lfsr.state), 32'hACE1);
    vivo = 2'b01;
    wait_tiro("launch_async", 1'b1);
    step(2);
    #1 reset = 1;
    #1;
    check("async_x", 32'(px), 0);
    check("async_y", 32'(py), 0);
    check("async_tiro", 32'(tiro), 0);
    #1 reset = 0;
    check("async_lfsr", 32'(dut.u_lfsr.state), 32'hACE1);
    fx = 11'd290;
    fy = 11'd80;
    vivas = 4'b0001;
    wait_tiro("launch_render", 1'b1);
    vivo = 2'b00;
    step(3);
    check("render_x", 32'(px), 300);
    check("render_y", 32'(py), 80);
    for (int i = 0; i < 6; i++) begin
      h = th[i];
      v = tv[i];
      exp_q.push_back(32'(trgb[i]));
      step();
      check("rgb", {8'h0, R, G, B}, exp_q.pop_front());
    end
    reiniciar = 1;
    step();
    reiniciar = 0;
    h = 10'd0;
    v = 10'd0;
    exp_q.push_back(32'd0);
    step();
    check("parked_rgb_00", {8'h0, R, G, B}, exp_q.pop_front());
    h = 10'd1;
    v = 10'd7;
    exp_q.push_back(32'd0);
    step();
    check("parked_rgb_17", {8'h0, R, G, B}, exp_q.pop_front());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
